// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// Request handshake is mem_req/mem_ready; the response is a single mem_rvalid beat.
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM feeding a core one instruction at a time.
// A fetch is REQ -> WAIT -> EXEC; misaligned PCs and response timeouts trap in a sticky FAULT.
module fetch_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [31:0]  pc,
  output logic         en,
  output logic [31:0]  instruction,
  output logic         fault,
  output logic [31:0]  retired,
  fetch_unit_if.master mem
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StExec, StFault} state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] instr_q;
  logic [7:0]  wait_cnt_q;
  logic [31:0] retired_q;
  logic        en_q;
  logic        fault_q;
  logic        misaligned;

  assign misaligned = (pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      en_q       <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) state_q <= StReq;
        end
        StReq: begin
          wait_cnt_q <= '0;
          if (misaligned) begin
            state_q <= StFault;
            fault_q <= 1'b1;
          end else if (mem.mem_ready) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          // A response in the final allowed cycle still wins over the timeout.
          if (mem.mem_rvalid) begin
            instr_q    <= mem.mem_rdata;
            wait_cnt_q <= '0;
            state_q    <= StExec;
            en_q       <= 1'b1;
          end else if (wait_cnt_q == WaitLast) begin
            state_q <= StFault;
            fault_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StExec: begin
          retired_q <= retired_q + 32'd1;
          state_q   <= run ? StReq : StIdle;
        end
        StFault: begin
          state_q <= StFault;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The bus is decoded from state because pc advances on the same edge that leaves EXEC.
  assign mem.mem_req  = (state_q == StReq) && !misaligned;
  assign mem.mem_addr = mem.mem_req ? pc : 32'h0;

  assign en          = en_q;
  assign instruction = en_q ? instr_q : NOP;
  assign fault       = fault_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder and core PC model drive the DUT,
// a monitor compares every accepted request and every EXEC against scoreboard queues.
module tb_fetch_unit;

  localparam int unsigned Timeout = 4;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [31:0] pc  = 32'h0;
  logic        en;
  logic [31:0] instruction;
  logic        fault;
  logic [31:0] retired;

  fetch_unit_if bus ();

  fetch_unit #(
    .TIMEOUT (Timeout),
    .NOP     (Nop)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pc          (pc),
    .en          (en),
    .instruction (instruction),
    .fault       (fault),
    .retired     (retired),
    .mem         (bus)
  );

  initial forever #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  logic [31:0] exp_req  [$];
  logic [31:0] exp_exec [$];

  // Responder knobs
  int          ready_stall = 0;
  int          rv_lat      = 0;
  int          wait_left   = -1;
  bit          stray       = 1'b0;
  logic [31:0] addr_l      = 32'h0;

  bit          prev_stall  = 1'b0;
  logic [31:0] prev_addr   = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : {a[15:0], 16'h0113};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core model: PC advances when the fetched instruction executes.
  initial forever begin
    @(negedge clk);
    if (en) pc = pc + 32'd4;
  end

  // Memory responder
  initial begin : responder
    bit          acc;
    logic [31:0] acc_addr;
    int          stall_left;
    stall_left     = 0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      acc      = bus.mem_req && bus.mem_ready;
      acc_addr = bus.mem_addr;
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      if (acc) begin
        wait_left = rv_lat;
        addr_l    = acc_addr;
      end
      if (wait_left == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_word(addr_l);
        wait_left      = -1;
      end else if (wait_left > 0) begin
        wait_left--;
      end
      if (stray) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_0BAD;
        stray          = 1'b0;
      end
      if (bus.mem_req) begin
        if (stall_left > 0) begin
          bus.mem_ready = 1'b0;
          stall_left--;
        end else begin
          bus.mem_ready = 1'b1;
        end
      end else begin
        bus.mem_ready = 1'b0;
        stall_left    = ready_stall;
      end
    end
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (en) begin
        if (exp_exec.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL exec_unexpected: got instruction %h, required no execution", instruction);
        end else begin
          check("exec_instr", instruction, exp_exec.pop_front());
        end
      end else begin
        check("instr_nop", instruction, Nop);
      end
      if (!bus.mem_req) check("addr_zero", bus.mem_addr, 32'h0);
      if (prev_stall) begin
        check("req_hold", 32'(bus.mem_req), 32'd1);
        check("addr_hold", bus.mem_addr, prev_addr);
      end
      if (bus.mem_req && bus.mem_ready) begin
        if (exp_req.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL req_unexpected: got request at %h, required none", bus.mem_addr);
        end else begin
          check("req_addr", bus.mem_addr, exp_req.pop_front());
        end
      end
      prev_stall = bus.mem_req && !bus.mem_ready;
      prev_addr  = bus.mem_addr;
    end
  end

  task automatic wait_en(input int bound, output int n_req);
    bit seen;
    n_req = 0;
    seen  = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_req) n_req++;
      if (en) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL en_timeout: got no en within %0d cycles, required one", bound);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, 32'(en), 32'd0);
    check({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_addr"}, bus.mem_addr, 32'h0);
    check({tag, "_instr"}, instruction, Nop);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_retired"}, retired, 32'd0);
  endtask

  initial begin : stim
    int n_req;
    int start;
    int n_en;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");

    // Zero-wait single fetch
    @(negedge clk);
    rst = 1'b1;
    pc  = 32'h0;
    exp_req.push_back(32'h0);
    exp_exec.push_back(32'h0050_0093);
    run   = 1'b1;
    start = cyc;
    @(posedge clk);
    #1 run = 1'b0;
    wait_en(8, n_req);
    check("zw_latency", 32'(cyc - start), 32'd3);
    check("zw_req_cycles", 32'(n_req), 32'd1);
    @(negedge clk);
    check("zw_retired", retired, 32'd1);
    check("zw_idle_req", 32'(bus.mem_req), 32'd0);

    // Back-to-back throughput, one instruction every 3 cycles
    pc = 32'h10;
    exp_req.push_back(32'h10);
    exp_exec.push_back(32'h0010_0113);
    exp_req.push_back(32'h14);
    exp_exec.push_back(32'h0014_0113);
    exp_req.push_back(32'h18);
    exp_exec.push_back(32'h0018_0113);
    exp_req.push_back(32'h1C);
    exp_exec.push_back(32'h001C_0113);
    run   = 1'b1;
    start = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_en(8, n_req);
      check("tp_spacing", 32'(cyc - start), 32'd3);
      start = cyc;
      if (k == 3) run = 1'b0;
    end
    @(negedge clk);
    check("tp_retired", retired, 32'd5);
    check("tp_idle_req", 32'(bus.mem_req), 32'd0);

    // Backpressure: ready low for 4 cycles
    ready_stall = 4;
    pc          = 32'h20;
    exp_req.push_back(32'h20);
    exp_exec.push_back(32'h0020_0113);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    wait_en(16, n_req);
    check("bp_req_cycles", 32'(n_req), 32'd5);
    @(negedge clk);
    check("bp_retired", retired, 32'd6);
    ready_stall = 0;
    @(negedge clk);

    // Run dropped during WAIT; response in the last cycle before timeout
    rv_lat = 3;
    pc     = 32'h30;
    exp_req.push_back(32'h30);
    exp_exec.push_back(32'h0030_0113);
    @(negedge clk);
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 run = 1'b0;
    wait_en(16, n_req);
    @(negedge clk);
    check("rd_retired", retired, 32'd7);
    check("rd_req_low", 32'(bus.mem_req), 32'd0);
    repeat (3) @(negedge clk);
    check("rd_idle_req", 32'(bus.mem_req), 32'd0);
    check("rd_no_fault", 32'(fault), 32'd0);

    // rvalid in the acceptance cycle must be ignored
    rv_lat = 0;
    pc     = 32'h40;
    exp_req.push_back(32'h40);
    exp_exec.push_back(32'h0040_0113);
    run   = 1'b1;
    stray = 1'b1;
    start = cyc;
    @(posedge clk);
    #1 run = 1'b0;
    wait_en(8, n_req);
    check("st_latency", 32'(cyc - start), 32'd3);
    @(negedge clk);
    check("st_retired", retired, 32'd8);
    stray = 1'b1;
    repeat (3) @(negedge clk);

    // Reset mid-WAIT, then a late rvalid
    rv_lat = -1;
    pc     = 32'h50;
    exp_req.push_back(32'h50);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rw");
    @(negedge clk);
    rst   = 1'b1;
    stray = 1'b1;
    n_en  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (en) n_en++;
    end
    check("rw_no_exec", 32'(n_en), 32'd0);
    check("rw_retired", retired, 32'd0);

    // Misaligned PC
    pc = 32'h6;
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    @(negedge clk);
    check("ma_req_low", 32'(bus.mem_req), 32'd0);
    check("ma_fault_pre", 32'(fault), 32'd0);
    @(negedge clk);
    check("ma_fault", 32'(fault), 32'd1);
    repeat (3) @(negedge clk);
    check("ma_fault_sticky", 32'(fault), 32'd1);
    check("ma_req_stays_low", 32'(bus.mem_req), 32'd0);
    rst = 1'b0;
    #1 check("ma_fault_cleared", 32'(fault), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Timeout with TIMEOUT=4 and no response
    pc = 32'h60;
    exp_req.push_back(32'h60);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    check("to_fault_pre", 32'(fault), 32'd0);
    @(negedge clk);
    check("to_fault", 32'(fault), 32'd1);
    run = 1'b1;
    repeat (4) @(negedge clk);
    check("to_en_low", 32'(en), 32'd0);
    check("to_req_low", 32'(bus.mem_req), 32'd0);
    check("to_fault_sticky", 32'(fault), 32'd1);
    run = 1'b0;
    rst = 1'b0;
    #1 check("to_fault_cleared", 32'(fault), 32'd0);

    check("req_queue_drained", 32'(exp_req.size()), 32'd0);
    check("exec_queue_drained", 32'(exp_exec.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1, "watchdog");
  end

endmodule
